// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the pc_sequencer fetch-PC block.
package pc_seq_pkg;

  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_e;

  localparam int PC_STEP       = 4;
  localparam int MAX_FLUSH_CYC = 3;
  localparam int FLUSH_CNT_W   = $clog2(MAX_FLUSH_CYC);

endpackage

// File: rtl/pc_sequencer_if.sv
// Branch-unit / IF-stage signal bundle for pc_sequencer.
// PC_SEQ_STATS_EN adds the taken_cnt/stall_cnt statistics outputs.
interface pc_sequencer_if #(parameter int PC_W = 9);

  logic            stall;
  logic            pc_sel;
  logic [31:0]     br_pc;
  logic            halt;
  logic            resume;
  logic [PC_W-1:0] pc;
  logic            pc_valid;
  logic            flush_if;
  logic            flush_id;
  logic            halted;
  logic            misalign_err;
`ifdef PC_SEQ_STATS_EN
  logic [31:0]     taken_cnt;
  logic [31:0]     stall_cnt;

  modport master (output stall, pc_sel, br_pc, halt, resume,
                  input  pc, pc_valid, flush_if, flush_id, halted, misalign_err,
                         taken_cnt, stall_cnt);
  modport slave  (input  stall, pc_sel, br_pc, halt, resume,
                  output pc, pc_valid, flush_if, flush_id, halted, misalign_err,
                         taken_cnt, stall_cnt);
`else
  modport master (output stall, pc_sel, br_pc, halt, resume,
                  input  pc, pc_valid, flush_if, flush_id, halted, misalign_err);
  modport slave  (input  stall, pc_sel, br_pc, halt, resume,
                  output pc, pc_valid, flush_if, flush_id, halted, misalign_err);
`endif

endinterface

// File: rtl/pc_sequencer_flush_counter.sv
// Loadable down-counter; its registered flag stays high on the load cycle
// and for every following cycle in which the count was still nonzero.
import pc_seq_pkg::*;

module flush_counter (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [FLUSH_CNT_W-1:0] load_val,
  output logic [FLUSH_CNT_W-1:0] count,
  output logic                   flush
);

  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic                   flush_q, flush_d;

  always_comb begin
    cnt_d   = cnt_q;
    flush_d = load | (cnt_q != '0);
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  assign count = cnt_q;
  assign flush = flush_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: redirect/stall/halt handling and post-redirect flushes.
// Optional statistics counters are enabled by defining PC_SEQ_STATS_EN.
//   state | meaning
//   RUN   | sequential fetch, pc += 4 unless stalled
//   FLUSH | redirect taken, flush pulses still counting down
//   HALT  | parked, pc frozen and invalid until resume
import pc_seq_pkg::*;

module pc_sequencer #(
  parameter int PC_W      = 9,
  parameter int RESET_PC  = 0,
  parameter int FLUSH_CYC = 2
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  localparam logic [1:0]             S_RUN      = RUN;
  localparam logic [1:0]             S_FLUSH    = FLUSH;
  localparam logic [1:0]             S_HALT     = HALT;
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYC - 1);

  logic [1:0]             state_q, state_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic                   pc_valid_q, pc_valid_d;
  logic                   mis_q, mis_d;
  logic                   fc_load;
  logic [FLUSH_CNT_W-1:0] fc_val;
  logic [FLUSH_CNT_W-1:0] fc_count;
  logic                   fc_flush;
  logic                   redirect;
  logic                   stall_cyc;
  logic [PC_W-1:0]        tgt;
  logic                   unused_br_hi;

  assign tgt          = {bus.br_pc[PC_W-1:2], 2'b00};
  assign unused_br_hi = ^bus.br_pc[31:PC_W];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    mis_d     = mis_q;
    fc_load   = 1'b0;
    fc_val    = FLUSH_LOAD;
    redirect  = 1'b0;
    stall_cyc = 1'b0;
    if (state_q == S_HALT) begin
      if (bus.resume)
        state_d = S_RUN;
    end else if (bus.halt) begin
      // Halt flushes the younger stages for one cycle only.
      pc_d    = bus.br_pc[PC_W-1:0];
      state_d = S_HALT;
      fc_load = 1'b1;
      fc_val  = '0;
    end else if (bus.pc_sel) begin
      pc_d     = tgt;
      state_d  = S_FLUSH;
      fc_load  = 1'b1;
      redirect = 1'b1;
      if (bus.br_pc[1:0] != 2'b00)
        mis_d = 1'b1;
    end else begin
      if (bus.stall)
        stall_cyc = 1'b1;
      else
        pc_d = pc_q + PC_W'(PC_STEP);
      if (state_q == S_FLUSH && fc_count <= 1)
        state_d = S_RUN;
    end
    pc_valid_d = (state_d != S_HALT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_RUN;
      pc_q       <= PC_W'(RESET_PC);
      pc_valid_q <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      mis_q      <= mis_d;
    end
  end

  flush_counter u_flush_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (fc_load),
    .load_val (fc_val),
    .count    (fc_count),
    .flush    (fc_flush)
  );

`ifdef PC_SEQ_STATS_EN
  logic [31:0] taken_q, taken_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    taken_d = taken_q;
    stall_d = stall_q;
    if (redirect && taken_q != 32'hFFFF_FFFF)
      taken_d = taken_q + 32'd1;
    if (stall_cyc && stall_q != 32'hFFFF_FFFF)
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      taken_q <= '0;
      stall_q <= '0;
    end else begin
      taken_q <= taken_d;
      stall_q <= stall_d;
    end
  end

  assign bus.taken_cnt = taken_q;
  assign bus.stall_cnt = stall_q;
`else
  logic unused_stats;
  assign unused_stats = redirect ^ stall_cyc;
`endif

  assign bus.pc           = pc_q;
  assign bus.pc_valid     = pc_valid_q;
  assign bus.flush_if     = fc_flush;
  assign bus.flush_id     = fc_flush;
  assign bus.halted       = (state_q == S_HALT);
  assign bus.misalign_err = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then random
// traffic, all outputs compared every cycle against a behavioural model.
module tb_pc_sequencer;

  localparam int PC_W      = 9;
  localparam int RESET_PC  = 0;
  localparam int FLUSH_CYC = 2;
  localparam int PC_SPACE  = 1 << PC_W;

  logic clk;
  logic reset;

  pc_sequencer_if #(.PC_W(PC_W)) bus ();

  pc_sequencer #(.PC_W(PC_W), .RESET_PC(RESET_PC), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: remaining flush cycles rather than a counter.
  int unsigned m_pc;
  bit          m_halted;
  bit          m_valid;
  bit          m_mis;
  int          m_flush_left;
  longint      m_taken;
  longint      m_stalls;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (!reset) begin
      m_pc         = RESET_PC;
      m_halted     = 1'b0;
      m_valid      = 1'b0;
      m_mis        = 1'b0;
      m_flush_left = 0;
      m_taken      = 0;
      m_stalls     = 0;
    end else begin
      if (m_flush_left > 0) m_flush_left--;
      if (m_halted) begin
        if (bus.resume) m_halted = 1'b0;
      end else if (bus.halt) begin
        m_pc         = bus.br_pc % PC_SPACE;
        m_halted     = 1'b1;
        m_flush_left = 1;
      end else if (bus.pc_sel) begin
        m_pc         = (bus.br_pc % PC_SPACE) & ~32'd3;
        m_flush_left = FLUSH_CYC;
        if (bus.br_pc % 4 != 0) m_mis = 1'b1;
        m_taken++;
      end else if (bus.stall) begin
        m_stalls++;
      end else begin
        m_pc = (m_pc + 4) % PC_SPACE;
      end
      m_valid = !m_halted;
    end
  endtask

  task automatic cyc(input bit rst, input bit stl, input bit sel,
                     input logic [31:0] br, input bit hlt, input bit res);
    reset      = rst;
    bus.stall  = stl;
    bus.pc_sel = sel;
    bus.br_pc  = br;
    bus.halt   = hlt;
    bus.resume = res;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("pc",           32'(bus.pc),       m_pc);
    chk("pc_valid",     32'(bus.pc_valid), 32'(m_valid));
    chk("flush_if",     32'(bus.flush_if), 32'(m_flush_left > 0));
    chk("flush_id",     32'(bus.flush_id), 32'(m_flush_left > 0));
    chk("halted",       32'(bus.halted),   32'(m_halted));
    chk("misalign_err", 32'(bus.misalign_err), 32'(m_mis));
`ifdef PC_SEQ_STATS_EN
    chk("taken_cnt",    bus.taken_cnt,     32'(m_taken));
    chk("stall_cnt",    bus.stall_cnt,     32'(m_stalls));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 32'h0, 0, 0);
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 32'h0, 0, 0);
    cyc(0, 0, 0, 32'h0, 0, 0);
  endtask

  initial begin
    reset = 1'b0; bus.stall = 0; bus.pc_sel = 0; bus.br_pc = '0; bus.halt = 0; bus.resume = 0;

    // Reset release and sequential wrap.
    do_reset();
    chk("rst_pc", 32'(bus.pc), 32'h0);
    chk("rst_valid", 32'(bus.pc_valid), 32'h0);
    chk("rst_flush", 32'(bus.flush_if), 32'h0);
    idle(1);
    chk("first_inc", 32'(bus.pc), 32'h4);
    chk("first_valid", 32'(bus.pc_valid), 32'h1);
    idle(126);
    chk("top_pc", 32'(bus.pc), 32'd508);
    idle(1);
    chk("wrap_pc", 32'(bus.pc), 32'h0);

    // Plain redirect at pc=0x10.
    do_reset();
    idle(4);
    chk("pre_redir", 32'(bus.pc), 32'h10);
    cyc(1, 0, 1, 32'h40, 0, 0);
    chk("redir_pc", 32'(bus.pc), 32'h40);
    chk("redir_fl1", 32'(bus.flush_if), 32'h1);
    idle(1);
    chk("redir_pc2", 32'(bus.pc), 32'h44);
    chk("redir_fl2", 32'(bus.flush_id), 32'h1);
    idle(1);
    chk("redir_pc3", 32'(bus.pc), 32'h48);
    chk("redir_fl3", 32'(bus.flush_if), 32'h0);

    // Redirect beats stall.
    cyc(1, 1, 1, 32'h80, 0, 0);
    chk("rs_pc", 32'(bus.pc), 32'h80);
    idle(1);
    cyc(1, 1, 0, 32'h0, 0, 0);
    chk("rs_hold", 32'(bus.pc), 32'h84);

    // Halt, ignored redirects, resume.
    cyc(1, 0, 1, 32'h20, 1, 0);
    chk("halt_pc", 32'(bus.pc), 32'h20);
    chk("halt_h", 32'(bus.halted), 32'h1);
    chk("halt_v", 32'(bus.pc_valid), 32'h0);
    cyc(1, 0, 1, 32'h100, 0, 0);
    cyc(1, 1, 1, 32'h1F0, 1, 0);
    chk("halt_ign", 32'(bus.pc), 32'h20);
    cyc(1, 0, 0, 32'h0, 1, 1);
    chk("res_h", 32'(bus.halted), 32'h0);
    chk("res_pc", 32'(bus.pc), 32'h20);
    chk("res_v", 32'(bus.pc_valid), 32'h1);
    idle(1);
    chk("res_inc", 32'(bus.pc), 32'h24);

    // Truncated, misaligned redirect; sticky error.
    cyc(1, 0, 1, 32'h0000_0206, 0, 0);
    chk("mis_pc", 32'(bus.pc), 32'h4);
    chk("mis_set", 32'(bus.misalign_err), 32'h1);
    idle(5);
    cyc(1, 0, 1, 32'h40, 0, 0);
    chk("mis_sticky", 32'(bus.misalign_err), 32'h1);
    do_reset();
    chk("mis_clr", 32'(bus.misalign_err), 32'h0);

    // Reset in the middle of a flush.
    idle(2);
    cyc(1, 0, 1, 32'h40, 0, 0);
    cyc(0, 0, 0, 32'h0, 0, 0);
    chk("rflush_pc", 32'(bus.pc), RESET_PC);
    chk("rflush_fl", 32'(bus.flush_if), 32'h0);
    idle(1);
    chk("rflush_run", 32'(bus.pc), 32'(RESET_PC + 4));

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit rst, stl, sel, hlt, res;
      logic [31:0] br;
      rst = ($urandom_range(199) != 0);
      stl = ($urandom_range(3) == 0);
      sel = ($urandom_range(7) == 0);
      hlt = ($urandom_range(39) == 0);
      res = ($urandom_range(3) == 0);
      br  = $urandom;
      if (hlt || $urandom_range(3) != 0) br[1:0] = 2'b00;
      cyc(rst, stl, sel, br, hlt, res);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
